// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - MMIO UART transmitter with byte FIFO; even parity bit when UART_TX_PARITY_EN is defined
module uart_tx_mmio #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  addr_i,
    input  logic        write_en_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [15:0]   baud_div, frame_div, baud_cnt;
    logic [2:0]    state, bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic          full, empty, wr_txdata, push, pop, bit_end;
    logic [7:0]    count_byte;
    logic          unused_data_hi;

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign wr_txdata  = write_en_i && (addr_i == 8'h00);
    assign push       = wr_txdata && !full;
    assign pop        = (state == ST_IDLE) && !empty;
    assign bit_end    = (baud_cnt == 16'd0);
    assign count_byte = 8'(count);
    assign unused_data_hi = ^data_i[31:16];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= data_i[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // A set wins over a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            baud_div <= 16'(DEFAULT_DIV);
        end else begin
            if (wr_txdata && full)
                overflow <= 1'b1;
            else if (write_en_i && addr_i == 8'h04 && data_i[3])
                overflow <= 1'b0;
            if (write_en_i && addr_i == 8'h08)
                baud_div <= (data_i[15:0] == 16'd0) ? 16'd1 : data_i[15:0];
        end
    end

    // frame_div freezes the divisor for the whole frame so mid-frame writes only affect the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            frame_div  <= 16'd1;
            shift      <= '0;
            parity_bit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        shift      <= fifo_mem[rd_ptr];
                        parity_bit <= ^fifo_mem[rd_ptr];
                        bit_cnt    <= '0;
                        baud_cnt   <= baud_div - 16'd1;
                        frame_div  <= baud_div;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= frame_div - 16'd1;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= frame_div - 16'd1;
                        shift    <= {1'b0, shift[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
`else
                        if (bit_cnt == 3'd7) state <= ST_STOP;
`endif
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= frame_div - 16'd1;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) state <= ST_IDLE;
                    else         baud_cnt <= baud_cnt - 16'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decoded from the async-reset state so the line idles high the moment reset asserts.
    always_comb begin
        tx_o = 1'b1;
        case (state)
            ST_START:  tx_o = 1'b0;
            ST_DATA:   tx_o = shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_o = parity_bit;
`endif
            default:   ;
        endcase
    end

    always_comb begin
        data_o = '0;
        case (addr_i)
            8'h04:   data_o = {16'h0000, count_byte, 4'h0, overflow, empty, full, state != ST_IDLE};
            8'h08:   data_o = {16'h0000, baud_div};
            default: ;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - scoreboard bench for uart_tx_mmio: register reads and serial frames
module tb_uart_tx_mmio;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    typedef struct {
        logic [7:0] data;
        int         div;
        int         gap;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  addr_i;
    logic        write_en_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        tx_o;
    logic        rd_req;

    int n_checks = 0;
    int n_fail   = 0;
    int abort_cnt = 0;
    bit in_frame = 0;

    frame_t      frame_q [$];
    logic [31:0] rd_exp_q [$];
    logic [31:0] rd_mask_q [$];
    string       rd_name_q [$];

    uart_tx_mmio #(.FIFO_DEPTH(8), .DEFAULT_DIV(434)) dut (
        .clk(clk), .reset_n(reset_n), .addr_i(addr_i), .write_en_i(write_en_i),
        .data_i(data_i), .data_o(data_o), .tx_o(tx_o)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", n, act, exp);
        end
    endtask

    function automatic logic exp_level(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == NBITS - 1) return 1'b1;
        return ^d;
    endfunction

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        addr_i = a; data_i = d; write_en_i = 1'b1; rd_req = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input logic [31:0] m, input string n);
        @(posedge clk); #1;
        write_en_i = 1'b0; addr_i = a;
        rd_exp_q.push_back(e); rd_mask_q.push_back(m); rd_name_q.push_back(n);
        rd_req = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            write_en_i = 1'b0; rd_req = 1'b0;
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input int div, input int gap);
        frame_t f;
        f.data = d; f.div = div; f.gap = gap;
        frame_q.push_back(f);
    endtask

    task automatic wait_drain(input int budget, input string n);
        int k = 0;
        idle(1);
        while ((frame_q.size() != 0 || in_frame) && k < budget) begin
            idle(1);
            k++;
        end
        chk(n, 32'(k < budget), 32'd1);
    endtask

    // Register-read monitor.
    initial begin
        logic [31:0] e, m;
        string n;
        forever begin
            @(negedge clk);
            if (rd_req) begin
                e = rd_exp_q.pop_front();
                m = rd_mask_q.pop_front();
                n = rd_name_q.pop_front();
                chk(n, data_o & m, e & m);
            end
        end
    end

    // Serial-line monitor: a falling edge from idle starts a frame that is checked bit by bit.
    initial begin
        logic   prev = 1'b1;
        logic   lvl, act;
        bit     good, ab;
        int     ncyc = 0, last_end = -1000, fidx = 0, b, c;
        frame_t f;
        forever begin
            @(negedge clk);
            ncyc++;
            if (reset_n && !in_frame && prev && !tx_o) begin
                if (frame_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d with no frame expected", ncyc);
                end else begin
                    f = frame_q.pop_front();
                    fidx++;
                    if (f.gap >= 0)
                        chk($sformatf("frame%0d_idle_gap", fidx), 32'(ncyc - last_end - 1), 32'(f.gap));
                    in_frame = 1;
                    ab = 0;
                    b = 0;
                    while (b < NBITS && !ab) begin
                        lvl = exp_level(f.data, b);
                        good = 1;
                        act = lvl;
                        c = 0;
                        while (c < f.div && !ab) begin
                            if (b != 0 || c != 0) begin
                                @(negedge clk);
                                ncyc++;
                            end
                            if (!reset_n) ab = 1;
                            else if (tx_o !== lvl && good) begin
                                good = 0;
                                act = tx_o;
                            end
                            c++;
                        end
                        if (!ab)
                            chk($sformatf("frame%0d_data%02h_bit%0d", fidx, f.data, b), 32'(act), 32'(lvl));
                        b++;
                    end
                    if (ab) abort_cnt++;
                    else last_end = ncyc;
                    in_frame = 0;
                end
            end
            prev = tx_o;
        end
    end

    initial begin
        reset_n = 1'b0; addr_i = '0; write_en_i = 1'b0; data_i = '0; rd_req = 1'b0;
        idle(3);
        reset_n = 1'b1;
        #1 chk("reset_tx_idle", 32'(tx_o), 32'd1);

        rd(8'h04, 32'h0000_0004, 32'hFFFF_FFFF, "reset_status");
        rd(8'h08, 32'h0000_01B2, 32'hFFFF_FFFF, "reset_baud_div");
        rd(8'h00, 32'h0000_0000, 32'hFFFF_FFFF, "txdata_reads_zero");
        wr(8'h0C, 32'h0000_FFFF);
        rd(8'h0C, 32'h0000_0000, 32'hFFFF_FFFF, "unmapped_reads_zero");
        rd(8'h08, 32'h0000_01B2, 32'hFFFF_FFFF, "unmapped_write_ignored");

        // Single 0xA5 frame at div 4.
        wr(8'h08, 32'd4);
        wr(8'h00, 32'h0000_00A5);
        push_frame(8'hA5, 4, -1);
        wait_drain(200, "drain_a5");
        rd(8'h04, 32'h0000_0004, 32'hFFFF_FFFF, "status_after_a5");

        // Nine back-to-back writes at div 1: the first pop makes room for the ninth.
        wr(8'h08, 32'd1);
        for (int i = 0; i < 9; i++) begin
            wr(8'h00, 32'(i + 1));
            push_frame(8'(i + 1), 1, (i == 0) ? -1 : 1);
        end
        rd(8'h04, 32'h0000_0000, 32'h0000_0008, "nine_writes_no_overflow");
        wait_drain(500, "drain_nine");
        rd(8'h04, 32'h0000_0004, 32'hFFFF_FFFF, "status_after_nine");

        // Ten writes at div 100: count saturates at 8, tenth byte dropped.
        wr(8'h08, 32'd100);
        for (int i = 0; i < 10; i++) begin
            wr(8'h00, 32'(8'h10 + i));
            if (i < 9) push_frame(8'(8'h10 + i), 100, (i == 0) ? -1 : 1);
        end
        rd(8'h04, 32'h0000_080B, 32'hFFFF_FFFF, "full_with_overflow");
        wr(8'h04, 32'h0000_0008);
        rd(8'h04, 32'h0000_0000, 32'h0000_0008, "overflow_cleared");
        wait_drain(12000, "drain_ten");
        rd(8'h04, 32'h0000_0004, 32'hFFFF_FFFF, "status_after_ten");

        // Divisor zero stored as one; mid-frame divisor change applies to the next frame.
        wr(8'h08, 32'd0);
        rd(8'h08, 32'h0000_0001, 32'hFFFF_FFFF, "baud_div_zero_as_one");
        wr(8'h08, 32'd4);
        wr(8'h00, 32'h0000_003C);
        push_frame(8'h3C, 4, -1);
        wr(8'h00, 32'h0000_005A);
        push_frame(8'h5A, 8, 1);
        idle(6);
        wr(8'h08, 32'd8);
        rd(8'h08, 32'h0000_0008, 32'hFFFF_FFFF, "baud_div_mid_frame");
        wait_drain(400, "drain_div_change");

        // Reset during DATA with more bytes queued: frame lost, FIFO flushed.
        wr(8'h08, 32'd4);
        wr(8'h00, 32'h0000_00F0);
        push_frame(8'hF0, 4, -1);
        wr(8'h00, 32'h0000_0011);
        wr(8'h00, 32'h0000_0022);
        idle(10);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1 chk("tx_high_on_reset", 32'(tx_o), 32'd1);
        idle(2);
        reset_n = 1'b1;
        rd(8'h04, 32'h0000_0004, 32'hFFFF_FFFF, "status_after_reset");
        rd(8'h08, 32'h0000_01B2, 32'hFFFF_FFFF, "baud_div_after_reset");
        idle(200);

        chk("frames_outstanding", 32'(frame_q.size()), 32'd0);
        chk("aborted_frames", 32'(abort_cnt), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter in the custom-components window (addr[11:8] = 4'b1010), directly downstream of the load/store unit.
- Consumes the LSU's store address, write-enable and merged store word. Returns a combinational read word that the LSU muxes into load data.
- Buffers bytes in a small FIFO and serialises them LSB-first on a single TX line at a programmable baud divisor.

Parameters:
- FIFO_DEPTH, 8, TX byte FIFO entries; power of two, 2..64.
- DEFAULT_DIV, 434, reset value of BAUD_DIV in clocks per bit (50 MHz / 115200).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- addr_i  input  8  byte address within window (addr[7:0] from LSU).
- write_en_i  input  1  store strobe, already window-decoded by LSU.
- data_i  input  32  store word (LSU-merged for sb/sh).
- data_o  output  32  read word, combinational from addr_i and current state.
- tx_o  output  1  serial line, idle high.

Behaviour:
- Register map (addr_i):
  - 0x00 TXDATA: write pushes data_i[7:0]; reads 0.
  - 0x04 STATUS (read-only except bit 3):
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[15:8] FIFO count
    - other bits 0.
  - 0x08 BAUD_DIV: RW, bits[15:0]; upper bits read 0.
  - Any other address: reads 0, writes ignored.
- Reads have no side effects; data_o is combinational, zero latency.
- Reset: FIFO empty, rd/wr pointers 0, overflow 0, BAUD_DIV = DEFAULT_DIV, FSM IDLE, tx_o = 1. Hence data_o at 0x04 = 0x0000_0004 and at 0x08 = DEFAULT_DIV.
- Push:
  - Occurs on write_en_i with addr_i = 0x00 and full = 0.
  - A push while full is dropped and sets overflow.
  - A pop in the same cycle does not rescue a push issued while full.
- Overflow clear: a write to 0x04 with data_i[3] = 1. A set and a clear in the same cycle leave overflow = 1.
- BAUD_DIV write: a value of 0 is stored as 1. The divisor is latched into the frame at START entry, so a mid-frame write affects the next frame only.
- FIFO: count ranges 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop when not full leaves count unchanged.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: if not empty, pop head into the shift register, load bit counter 0 and baud counter div-1, go to START next cycle. tx_o = 1.
  - START: tx_o = 0 for div cycles.
  - DATA: tx_o = shift[0] for div cycles per bit, shift right, 8 bits.
  - STOP: tx_o = 1 for div cycles, then IDLE.
- Bit timing: the baud counter decrements each clock; a bit ends when it reaches 0 and reloads div-1.
- Frame length: 10*div clocks without parity, 11*div with parity.
- Back-to-back: IDLE is held exactly 1 cycle between frames when the FIFO is non-empty.
- busy is high from the cycle after the pop through the last STOP cycle.
- Reset mid-frame: tx_o returns to 1 immediately (async). The FIFO is flushed and the frame is lost.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: adds the PARITY state between DATA and STOP. tx_o = even parity (XOR of the 8 data bits) for div cycles.
- Undefined: 8N1 only, the PARITY state does not exist, and the frame is 10*div clocks.

Test Plan:
- Reset then read 0x04 and 0x08 -> 0x0000_0004 and 0x0000_01B2; tx_o = 1.
- Write 0x08 = 4, write 0x00 = 0xA5 -> starting the cycle after the pop, tx_o is:
  - 0 for 4 clocks
  - then bits 1,0,1,0,0,1,0,1, 4 clocks each
  - then 1 for 4 clocks
  - then busy = 0.
  - With UART_TX_PARITY_EN: a parity bit of 0 for 4 clocks precedes STOP.
- div = 1, write 9 bytes 0x01..0x09 in consecutive cycles with FIFO_DEPTH = 8 -> first pop frees one slot, so all 9 are accepted, overflow = 0. Bytes go out back-to-back with a 1-cycle IDLE gap, in order.
- div = 100, write 10 bytes in consecutive cycles -> count saturates at 8 (full = 1), one byte is dropped, STATUS bit3 = 1. Writing 0x04 = 0x8 clears bit3.
- Write 0x08 = 0 -> reads back 1. Write 0x08 = 8 mid-frame -> the current frame keeps the old div, and the next frame uses 8.
- Assert reset_n low mid-DATA with 3 bytes queued -> tx_o = 1 the same cycle. After release: empty = 1, busy = 0, no further frames.
